// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the seven-segment display scheduler:
// sequencing states, display limit and segment patterns (active-low {g,f,e,d,c,b,a}).
package seg_disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    CAPTURE
  } state_e;

  localparam logic [26:0] MAX_DISP  = 27'd99_999_999;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam logic [6:0]  SEG_DASH  = 7'h3F;

  function automatic logic [6:0] seg_pattern(input logic [3:0] val);
    logic [6:0] pat;
    case (val)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit seven-segment driver: digit scan divider, leading-zero
// blanking, overflow dashes and source-marker decimal point. Outputs are registered.
module seg_scan_driver
  import seg_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50_000,
  parameter int IDX_W    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      i_bcd,
  input  logic             i_ovf,
  input  logic             i_blank_lz,
  input  logic [IDX_W-1:0] i_src_idx,
  output logic [7:0]       o_an,
  output logic [6:0]       o_seg,
  output logic             o_dp
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       digit_q, digit_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic [3:0] digit_val [8];
  logic [7:0] digit_nz;
  logic [7:0] zero_above;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
      assign digit_val[gi] = i_bcd[4*gi +: 4];
      assign digit_nz[gi]  = |i_bcd[4*gi +: 4];
    end
  endgenerate

  // zero_above[d]: digit d and every more-significant digit are zero
  always_comb begin
    zero_above    = '0;
    zero_above[7] = ~digit_nz[7];
    for (int i = 6; i >= 0; i--) begin
      zero_above[i] = ~digit_nz[i] & zero_above[i+1];
    end
  end

  always_comb begin
    div_d   = div_q + 1'b1;
    digit_d = digit_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d   = '0;
      digit_d = digit_q + 3'd1;
    end

    an_d = ~(8'b1 << digit_q);
    if (i_ovf) begin
      seg_d = SEG_DASH;
    end else if (i_blank_lz && (digit_q != 3'd0) && zero_above[digit_q]) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = seg_pattern(digit_val[digit_q]);
    end
    dp_d = (int'(i_src_idx) == int'(digit_q)) ? 1'b0 : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      digit_q <= '0;
      an_q    <= 8'hFE;
      seg_q   <= 7'h40;
      dp_q    <= 1'b1;
    end else begin
      div_q   <= div_d;
      digit_q <= digit_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign o_an  = an_q;
  assign o_seg = seg_q;
  assign o_dp  = dp_q;

endmodule

// File: rtl/seg_display_scheduler.sv
// Arbitrates N_SRC status values onto one shared binary-to-BCD decoder, holds each
// value until the decoder settles, captures the BCD and hands it to the scan driver.
module seg_display_scheduler
  import seg_disp_pkg::*;
#(
  parameter int N_SRC    = 4,
  parameter int DEC_LAT  = 9,
  parameter int DWELL    = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_SRC*27-1:0]      i_src_data,
  input  logic [N_SRC-1:0]         i_src_upd,
  input  logic                     i_auto,
  input  logic [$clog2(N_SRC)-1:0] i_sel,
  input  logic                     i_blank_lz,
  output logic [26:0]              o_dec_data,
  input  logic [31:0]              i_dec_seven,
  output logic [$clog2(N_SRC)-1:0] o_src_idx,
  output logic                     o_busy,
  output logic                     o_ovf,
  output logic [7:0]               o_an,
  output logic [6:0]               o_seg,
  output logic                     o_dp
);

  localparam int SEL_W = $clog2(N_SRC);
  localparam int N_PAD = 2 ** SEL_W;
  localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int LAT_W = (DEC_LAT > 1) ? $clog2(DEC_LAT) : 1;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [SEL_W-1:0] auto_idx_q, auto_idx_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             pending_q, pending_d;
  logic [26:0]      dec_data_q, dec_data_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      bcd_q, bcd_d;

  logic [26:0]      src_arr [N_PAD];
  logic [N_PAD-1:0] upd_ext;
  logic [SEL_W-1:0] tgt_idx;
  logic             pending_set;

  // Pad to a power of two so idx_q can index without an out-of-range read
  generate
    for (genvar gi = 0; gi < N_PAD; gi++) begin : g_src
      if (gi < N_SRC) begin : g_real
        assign src_arr[gi] = i_src_data[27*gi +: 27];
        assign upd_ext[gi] = i_src_upd[gi];
      end else begin : g_pad
        assign src_arr[gi] = '0;
        assign upd_ext[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    tgt_idx    = auto_idx_q;
    auto_idx_d = auto_idx_q;
    dwell_d    = '0;
    if (i_auto) begin
      dwell_d = dwell_q + 1'b1;
      if (dwell_q == DW_W'(DWELL - 1)) begin
        dwell_d    = '0;
        auto_idx_d = (auto_idx_q == SEL_W'(N_SRC - 1)) ? '0 : auto_idx_q + 1'b1;
      end
    end else begin
      tgt_idx = (i_sel > SEL_W'(N_SRC - 1)) ? SEL_W'(N_SRC - 1) : i_sel;
    end
  end

  assign pending_set = upd_ext[idx_q] | ((state_q == IDLE) && (tgt_idx != idx_q));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    lat_d      = lat_q;
    dec_data_d = dec_data_q;
    busy_d     = busy_q;
    ovf_d      = ovf_q;
    bcd_d      = bcd_q;
    pending_d  = pending_q | pending_set;
    case (state_q)
      IDLE: begin
        idx_d = tgt_idx;
        if (pending_q) state_d = LOAD;
      end
      LOAD: begin
        dec_data_d = src_arr[idx_q];
        lat_d      = '0;
        busy_d     = 1'b1;
        // A fresh update arriving while we latch still forces another pass
        pending_d  = pending_set;
        state_d    = WAIT;
      end
      WAIT: begin
        if (lat_q == LAT_W'(DEC_LAT - 1)) state_d = CAPTURE;
        else                              lat_d   = lat_q + 1'b1;
      end
      CAPTURE: begin
        bcd_d   = i_dec_seven;
        ovf_d   = (dec_data_q > MAX_DISP);
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      auto_idx_q <= '0;
      dwell_q    <= '0;
      lat_q      <= '0;
      pending_q  <= 1'b1;
      dec_data_q <= '0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      auto_idx_q <= auto_idx_d;
      dwell_q    <= dwell_d;
      lat_q      <= lat_d;
      pending_q  <= pending_d;
      dec_data_q <= dec_data_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
    end
  end

  assign o_dec_data = dec_data_q;
  assign o_src_idx  = idx_q;
  assign o_busy     = busy_q;
  assign o_ovf      = ovf_q;

  seg_scan_driver #(
    .SCAN_DIV (SCAN_DIV),
    .IDX_W    (SEL_W)
  ) u_scan (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_bcd      (bcd_q),
    .i_ovf      (ovf_q),
    .i_blank_lz (i_blank_lz),
    .i_src_idx  (idx_q),
    .o_an       (o_an),
    .o_seg      (o_seg),
    .o_dp       (o_dp)
  );

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler with a delayed binary-to-BCD decoder model.
module tb_seg_display_scheduler;

  localparam int N_SRC    = 4;
  localparam int DEC_LAT  = 9;
  localparam int DWELL    = 20;
  localparam int SCAN_DIV = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N_SRC*27-1:0] src_data;
  logic [N_SRC-1:0]  src_upd = '0;
  logic              auto_mode = 1'b0;
  logic [1:0]        sel = 2'd0;
  logic              blank_lz = 1'b0;
  logic [26:0]       dec_data;
  logic [31:0]       dec_seven;
  logic [1:0]        src_idx;
  logic              busy, ovf, dp;
  logic [7:0]        an;
  logic [6:0]        seg;

  int n_vec = 0;
  int n_err = 0;
  int conv_cnt = 0;
  int cyc = 0;
  logic busy_prev = 1'b0;

  logic [26:0] pipe [8];

  always #5 clk = ~clk;

  seg_display_scheduler #(
    .N_SRC(N_SRC), .DEC_LAT(DEC_LAT), .DWELL(DWELL), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_src_data(src_data), .i_src_upd(src_upd),
    .i_auto(auto_mode), .i_sel(sel), .i_blank_lz(blank_lz),
    .o_dec_data(dec_data), .i_dec_seven(dec_seven), .o_src_idx(src_idx),
    .o_busy(busy), .o_ovf(ovf), .o_an(an), .o_seg(seg), .o_dp(dp)
  );

  function automatic logic [31:0] to_bcd(input logic [26:0] v);
    logic [31:0] r;
    int x;
    x = int'(v);
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Decoder model: result reflects the input seen 8 clocks earlier
  always @(posedge clk) begin
    pipe[0] <= dec_data;
    for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
  end
  assign dec_seven = to_bcd(pipe[7]);

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (busy && !busy_prev) conv_cnt = conv_cnt + 1;
    busy_prev = busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic set_src(input int k, input logic [26:0] v);
    src_data[27*k +: 27] = v;
  endtask

  task automatic pulse(input logic [N_SRC-1:0] m);
    src_upd = m;
    @(negedge clk);
    src_upd = '0;
  endtask

  task automatic wait_busy(input string tag);
    bit seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy) begin seen = 1; break; end
    end
    if (!seen) chk({tag, "_busy_timeout"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_an(input int d);
    logic [7:0] exp_an;
    exp_an = ~(8'b1 << d);
    for (int k = 0; k < 8*SCAN_DIV + 4; k++) begin
      @(negedge clk);
      if (an == exp_an) return;
    end
    chk($sformatf("an_timeout%0d", d), 32'(an), 32'(exp_an));
  endtask

  task automatic check_disp(input string tag, input logic [7:0][6:0] exp_seg, input int dp_digit);
    for (int d = 0; d < 8; d++) begin
      wait_an(d);
      chk($sformatf("%s_seg%0d", tag, d), 32'(seg), 32'(exp_seg[d]));
      chk($sformatf("%s_dp%0d", tag, d), 32'(dp), (d == dp_digit) ? 32'd0 : 32'd1);
    end
  endtask

  initial begin
    int c0, nb, k_hit, t_prev, cur;
    logic [1:0] exp_seq [4];
    src_data = '0;
    set_src(0, 27'd12345678);
    set_src(1, 27'd100_000_000);
    set_src(2, 27'd905);
    set_src(3, 27'd7);

    // Reset state
    repeat (10) @(negedge clk);
    chk("rst_dec_data", 32'(dec_data), 32'd0);
    chk("rst_src_idx", 32'(src_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_an", 32'(an), 32'hFE);
    chk("rst_seg", 32'(seg), 32'h40);
    chk("rst_dp", 32'(dp), 32'd1);

    // T1: conversion of source 0 after release; busy lasts DEC_LAT+1 cycles
    rst_n = 1'b1;
    wait_busy("t1");
    chk("t1_dec_data", 32'(dec_data), 32'd12345678);
    nb = 0;
    while (busy && nb < 40) begin nb++; @(negedge clk); end
    chk("t1_busy_len", 32'(nb), 32'(DEC_LAT + 1));
    check_disp("t1", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}, 0);

    // T2: index change mid-WAIT waits for the running conversion, then converts source 2
    c0 = conv_cnt;
    pulse(4'b0001);
    wait_busy("t2");
    repeat (2) @(negedge clk);
    sel = 2'd2;
    blank_lz = 1'b1;
    repeat (2) @(negedge clk);
    chk("t2_idx_hold", 32'(src_idx), 32'd0);
    repeat (40) @(negedge clk);
    chk("t2_conv", 32'(conv_cnt - c0), 32'd2);
    chk("t2_idx", 32'(src_idx), 32'd2);
    chk("t2_dec_data", 32'(dec_data), 32'd905);
    check_disp("t2", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h10, 7'h40, 7'h12}, 2);

    // T3: overflow dashes, then an update to 42 clears overflow after DEC_LAT+3 cycles
    sel = 2'd1;
    blank_lz = 1'b0;
    repeat (30) @(negedge clk);
    chk("t3_ovf", 32'(ovf), 32'd1);
    check_disp("t3", {8{7'h3F}}, 1);
    set_src(1, 27'd42);
    blank_lz = 1'b1;
    src_upd = 4'b0010;
    k_hit = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      src_upd = '0;
      if (!ovf) begin k_hit = k; break; end
    end
    chk("t3_latency", 32'(k_hit), 32'(DEC_LAT + 4));
    check_disp("t3b", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}, 1);

    // T4: strobe coalescing and ignored non-displayed strobes
    sel = 2'd0;
    repeat (30) @(negedge clk);
    c0 = conv_cnt;
    pulse(4'b0001);
    wait_busy("t4");
    pulse(4'b0001);
    @(negedge clk);
    pulse(4'b0001);
    @(negedge clk);
    pulse(4'b0001);
    repeat (40) @(negedge clk);
    chk("t4_coalesce", 32'(conv_cnt - c0), 32'd2);
    c0 = conv_cnt;
    pulse(4'b1010);
    repeat (30) @(negedge clk);
    chk("t4_ignored", 32'(conv_cnt - c0), 32'd0);

    // T5: auto rotation every DWELL cycles, one conversion per step
    exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd3; exp_seq[3] = 2'd0;
    c0 = conv_cnt;
    cur = int'(src_idx);
    t_prev = 0;
    auto_mode = 1'b1;
    for (int s = 0; s < 4; s++) begin
      k_hit = 0;
      for (int k = 0; k < 60; k++) begin
        @(negedge clk);
        if (int'(src_idx) != cur) begin k_hit = 1; break; end
      end
      chk($sformatf("t5_idx%0d", s), 32'(src_idx), 32'(exp_seq[s]));
      if (k_hit == 0) chk($sformatf("t5_timeout%0d", s), 32'(src_idx), 32'(exp_seq[s] + 2'd1));
      cur = int'(src_idx);
      if (s > 0) chk($sformatf("t5_dwell%0d", s), 32'(cyc - t_prev), 32'(DWELL));
      t_prev = cyc;
      if (s == 3) begin
        auto_mode = 1'b0;
      end else begin
        wait_an(cur);
        chk($sformatf("t5_dp%0d", s), 32'(dp), 32'd0);
      end
    end
    repeat (30) @(negedge clk);
    chk("t5_conv", 32'(conv_cnt - c0), 32'd4);

    // T6: asynchronous reset during WAIT, then source 0 reconverts
    sel = 2'd3;
    repeat (30) @(negedge clk);
    pulse(4'b1000);
    wait_busy("t6");
    repeat (3) @(negedge clk);
    chk("t6_pre_data", 32'(dec_data), 32'd7);
    rst_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_dec_data", 32'(dec_data), 32'd0);
    chk("t6_idx", 32'(src_idx), 32'd0);
    chk("t6_an", 32'(an), 32'hFE);
    chk("t6_seg", 32'(seg), 32'h40);
    chk("t6_dp", 32'(dp), 32'd1);
    sel = 2'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_busy("t6r");
    chk("t6_restart_data", 32'(dec_data), 32'd12345678);
    chk("t6_restart_idx", 32'(src_idx), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg_display_scheduler.md
Name: seg_display_scheduler

Overview:
- Shares one NumberDecoder (27-bit binary → 8-digit BCD, iterative; most-significant digit settles 8 cycles after input is stable) among N_SRC value sources. Sources are e.g. cycle counter, alignment score, cell count.
- Selects a source, holds its value on the decoder input until all digits settle, then captures the BCD result.
- Drives a time-multiplexed 8-digit seven-segment display from the captured result.
- Sits between the FPGA top-level status counters and the board display pins.

Parameters:
- N_SRC, 4, number of value sources (2..8).
- DEC_LAT, 9, cycles the decoder input is held before BCD capture (must be ≥ 8).
- DWELL, 50_000_000, cycles each source is shown in auto-rotate mode.
- SCAN_DIV, 50_000, cycles per digit during display scanning.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_src_data  in  N_SRC*27  packed source values; source k occupies [27k +: 27]
- i_src_upd  in  N_SRC  per-source one-cycle "value changed" strobes
- i_auto  in  1  1 = rotate sources every DWELL cycles; 0 = manual
- i_sel  in  $clog2(N_SRC)  manual source index; values ≥ N_SRC are clamped to N_SRC-1
- i_blank_lz  in  1  blank leading zeros
- o_dec_data  out  27  decoder input
- i_dec_seven  in  32  decoder BCD output; digit d occupies [4d +: 4]
- o_src_idx  out  $clog2(N_SRC)  source currently displayed
- o_busy  out  1  conversion in progress
- o_ovf  out  1  captured value exceeds 99_999_999
- o_an  out  8  digit enables, active-low, one-hot-low
- o_seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- o_dp  out  1  decimal point, active-low; used as source marker

Behaviour:
- Reset values (all asynchronous): o_dec_data=0, o_src_idx=0, o_busy=0, o_ovf=0, captured BCD=0, o_an=8'hFE, o_seg=7'h40 (shows "0"), o_dp=1, pending=1, all counters=0, FSM=IDLE.
- Source selection:
  - Auto mode: a dwell counter wraps at DWELL-1 and advances the index modulo N_SRC.
  - Manual mode: the index follows the clamped i_sel; the dwell counter is held at 0.
  - The index changes only in IDLE. A change requested while busy is applied on return to IDLE.
- Pending flag is set by:
  - a change of the displayed index, or
  - i_src_upd[idx] for the displayed source, in any state.
- Pending flag is cleared on entry to LOAD. A set and clear in the same cycle leaves the flag set.
- Strobes for non-displayed sources are ignored.
- FSM:
  - IDLE: if pending → LOAD.
  - LOAD (1 cycle): latch the selected source value into o_dec_data; clear the latency counter; o_busy=1 → WAIT.
  - WAIT: count to DEC_LAT-1, holding o_dec_data stable → CAPTURE.
  - CAPTURE (1 cycle): register i_dec_seven into the BCD buffer; o_ovf = (latched value > 99_999_999); o_busy=0 → IDLE.
- Latency: a strobe accepted in IDLE gives updated BCD visible DEC_LAT+3 cycles later. Back-to-back strobes coalesce into at most one extra conversion.
- Scanning:
  - A free-running divider advances digit d = 0..7 every SCAN_DIV cycles, wrapping 7→0.
  - o_an = ~(1<<d).
  - o_seg decodes BCD digit d: 0–9 standard patterns; codes 10–15 blank.
- Leading-zero blanking: when i_blank_lz=1, digit d is blanked if it and all higher digits are 0. Digit 0 is never blanked.
- Overflow: when o_ovf=1, every digit shows "-" (o_seg=7'h3F).
- o_dp is low only on digit o_src_idx, when o_src_idx < 8.
- The display shows the previous BCD until CAPTURE. There is no tearing mid-conversion.
- Reset mid-conversion aborts it. After release, pending=1 forces a fresh conversion of source 0.

Decomposition:
- Package seg_disp_pkg:
  - FSM state enum {IDLE, LOAD, WAIT, CAPTURE}
  - constant MAX_DISP = 27'd99_999_999
  - the 10-entry seven-segment pattern function and blank/dash constants
- Sub-module seg_scan_driver: divider, digit counter, blanking and segment decode. The arbitration/sequencing FSM stays in the top module.
- NumberDecoder is instantiated by the parent, not inside this block.

Test Plan:
- Reset release, source 0 = 27'd12345678, decoder attached → o_busy high for DEC_LAT+1 cycles. BCD becomes 32'h12345678; scan shows digits 8,7,…,1 on o_an FE..7F.
- Manual mode, i_sel 0→2 mid-WAIT, source 2 = 27'd905 → current conversion completes, then a second conversion runs. With i_blank_lz=1, digits 3–7 blank and "905" is shown.
- Source 1 = 27'd100_000_000 → o_ovf=1, all digits show 7'h3F. A later update to 27'd42 clears o_ovf.
- Three i_src_upd[0] strobes during one WAIT → exactly one extra conversion follows. A strobe on a non-displayed source triggers none.
- Auto mode, DWELL=20, N_SRC=4 → o_src_idx cycles 0,1,2,3,0, with one conversion per step. o_dp marks the digit equal to the index.
- Assert rst_n in WAIT → all outputs return to reset values asynchronously. After release, conversion of source 0 restarts.
